// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 key decoder: prefix parser, Shift/Caps tracking, ASCII mapping and event FIFO.
// Define PS2_KEYDEC_CAPSLOCK_EN to enable Caps Lock tracking on scan code 0x58.
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          EMIT_BREAK = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [7:0]                  out_ascii,
  output logic [7:0]                  out_scan,
  output logic                        out_make,
  output logic                        out_ext,
  output logic                        shift_held,
  output logic                        caps_on,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] scan;
    logic       make;
    logic       ext;
  } event_t;

  function automatic logic [7:0] key_ascii(input logic [7:0] code, input logic shift,
                                           input logic upper);
    logic [7:0] lower;
    logic [7:0] a;
    lower = 8'h00;
    a     = 8'h00;
    case (code)
      8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";  8'h23: lower = "d";
      8'h24: lower = "e";  8'h2B: lower = "f";  8'h34: lower = "g";  8'h33: lower = "h";
      8'h43: lower = "i";  8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
      8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";  8'h4D: lower = "p";
      8'h15: lower = "q";  8'h2D: lower = "r";  8'h1B: lower = "s";  8'h2C: lower = "t";
      8'h3C: lower = "u";  8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
      8'h35: lower = "y";  8'h1A: lower = "z";
      default: lower = 8'h00;
    endcase
    if (lower != 8'h00) begin
      a = upper ? (lower - 8'h20) : lower;
    end else begin
      case (code)
        8'h45:   a = shift ? ")" : "0";
        8'h16:   a = shift ? "!" : "1";
        8'h1E:   a = shift ? "@" : "2";
        8'h26:   a = shift ? "#" : "3";
        8'h25:   a = shift ? "$" : "4";
        8'h2E:   a = shift ? "%" : "5";
        8'h36:   a = shift ? "^" : "6";
        8'h3D:   a = shift ? "&" : "7";
        8'h3E:   a = shift ? "*" : "8";
        8'h46:   a = shift ? "(" : "9";
        8'h29:   a = 8'h20;
        8'h5A:   a = 8'h0D;
        8'h66:   a = 8'h08;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       is_e0, is_f0, is_e1;
  logic       ev_done, ev_make, ev_ext;

  assign is_e0 = in_data == 8'hE0;
  assign is_f0 = in_data == 8'hF0;
  assign is_e1 = in_data == 8'hE1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // E0/F0 accumulate into whichever prefix is already pending.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (in_valid) begin
      if (state_q == StSkip) begin
        skip_d = skip_q - 3'd1;
        if (skip_q <= 3'd1) begin
          state_d = StIdle;
          skip_d  = '0;
        end
      end else if (is_e1) begin
        state_d = StSkip;
        skip_d  = 3'd7;
      end else if (is_e0) begin
        state_d = (state_q == StBrk || state_q == StExtBrk) ? StExtBrk : StExt;
      end else if (is_f0) begin
        state_d = (state_q == StExt || state_q == StExtBrk) ? StExtBrk : StBrk;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    ev_done = in_valid && (state_q != StSkip) && !(is_e0 || is_f0 || is_e1);
    ev_make = (state_q == StIdle) || (state_q == StExt);
    ev_ext  = (state_q == StExt) || (state_q == StExtBrk);
  end

  logic base_key, caps_key, is_mod;
  logic lshift_q, rshift_q, caps_q;

  assign base_key = ev_done && !ev_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
    end else begin
      if (base_key && in_data == 8'h12) lshift_q <= ev_make;
      if (base_key && in_data == 8'h59) rshift_q <= ev_make;
    end
  end

`ifdef PS2_KEYDEC_CAPSLOCK_EN
  assign caps_key = in_data == 8'h58;
  always_ff @(posedge clk) begin
    if (rst) begin
      caps_q <= 1'b0;
    end else if (base_key && ev_make && caps_key) begin
      caps_q <= ~caps_q;
    end
  end
`else
  assign caps_key = 1'b0;
  assign caps_q   = 1'b0;
`endif

  assign shift_held = lshift_q | rshift_q;
  assign caps_on    = caps_q;
  assign is_mod     = !ev_ext && (in_data == 8'h12 || in_data == 8'h59 || caps_key);

  // One-entry stage between the parser and the FIFO; modifier state is the pre-byte value.
  logic   stage_valid;
  event_t stage_ev, new_ev;

  always_comb begin
    new_ev.ascii = ev_ext ? 8'h00 : key_ascii(in_data, shift_held, shift_held ^ caps_q);
    new_ev.scan  = in_data;
    new_ev.make  = ev_make;
    new_ev.ext   = ev_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_ev    <= '0;
    end else begin
      stage_valid <= ev_done && !is_mod && (ev_make || EMIT_BREAK);
      if (ev_done) stage_ev <= new_ev;
    end
  end

  event_t              mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                overflow_q;
  logic                full, pop, push;
  event_t              head;

  assign full = count_q == DepthCnt;
  assign pop  = out_valid && out_ready;
  assign push = stage_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= stage_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      if (stage_valid && !push) overflow_q <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr_q];
  assign out_valid = count_q != '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_ascii = out_valid ? head.ascii : 8'h00;
  assign out_scan  = out_valid ? head.scan : 8'h00;
  assign out_make  = out_valid & head.make;
  assign out_ext   = out_valid & head.ext;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (EMIT_BREAK 0/1, depths 4/8) tracked cycle by
// cycle against a queue-based reference, plus table and directed sequences.
module tb_ps2_key_decoder;

  localparam int unsigned D0 = 4;
  localparam int unsigned D1 = 8;
`ifdef PS2_KEYDEC_CAPSLOCK_EN
  localparam bit CapsEn = 1'b1;
`else
  localparam bit CapsEn = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] scan;
    logic       make;
    logic       ext;
  } ev_t;

  typedef struct {
    logic [7:0] modk;
    logic [7:0] scan;
    logic [7:0] exp_ascii;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       v0, mk0, ex0, sh0, cp0, of0;
  logic [7:0] as0, sc0;
  logic [2:0] cnt0;
  logic       v1, mk1, ex1, sh1, cp1, of1;
  logic [7:0] as1, sc1;
  logic [3:0] cnt1;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(D0), .EMIT_BREAK(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(v0), .out_ascii(as0), .out_scan(sc0), .out_make(mk0), .out_ext(ex0),
    .shift_held(sh0), .caps_on(cp0), .overflow(of0), .count(cnt0)
  );

  ps2_key_decoder #(.FIFO_DEPTH(D1), .EMIT_BREAK(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(v1), .out_ascii(as1), .out_scan(sc1), .out_make(mk1), .out_ext(ex1),
    .shift_held(sh1), .caps_on(cp1), .overflow(of1), .count(cnt1)
  );

  int n_chk = 0;
  int n_fail = 0;

  ev_t q0[$];
  ev_t q1[$];
  ev_t st_ev;
  bit  st_v0, st_v1, m_ovf0, m_ovf1;
  bit  m_lsh, m_rsh, m_caps, m_ext, m_brk;
  int  m_skip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] sc, input bit sh, input bit up);
    logic [7:0] letters [26];
    logic [7:0] digits [10];
    string sym;
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    sym = ")!@#$%^&*(";
    for (int i = 0; i < 26; i++) if (letters[i] == sc) return 8'((up ? 65 : 97) + i);
    for (int i = 0; i < 10; i++) if (digits[i] == sc) return sh ? sym[i] : 8'(48 + i);
    if (sc == 8'h29) return 8'h20;
    if (sc == 8'h5A) return 8'h0D;
    if (sc == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    st_ev = '0;
    st_v0 = 0; st_v1 = 0; m_ovf0 = 0; m_ovf1 = 0;
    m_lsh = 0; m_rsh = 0; m_caps = 0; m_ext = 0; m_brk = 0;
    m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit have, output ev_t e);
    bit is_mod;
    have = 0;
    e = '0;
    if (m_skip > 0) begin m_skip--; return; end
    if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    e.scan  = b;
    e.make  = !m_brk;
    e.ext   = m_ext;
    e.ascii = m_ext ? 8'h00 : ref_ascii(b, m_lsh | m_rsh, (m_lsh | m_rsh) ^ m_caps);
    is_mod = !m_ext && (b == 8'h12 || b == 8'h59 || (CapsEn && b == 8'h58));
    if (!m_ext && b == 8'h12) m_lsh = e.make;
    if (!m_ext && b == 8'h59) m_rsh = e.make;
    if (CapsEn && !m_ext && b == 8'h58 && e.make) m_caps = !m_caps;
    have  = !is_mod;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic check_all();
    chk("d0_valid", v0, q0.size() != 0);
    chk("d0_count", cnt0, q0.size());
    chk("d0_ovf", of0, m_ovf0);
    chk("d0_ascii", as0, q0.size() != 0 ? q0[0].ascii : 8'h00);
    chk("d0_scan", sc0, q0.size() != 0 ? q0[0].scan : 8'h00);
    chk("d0_make", mk0, q0.size() != 0 ? q0[0].make : 1'b0);
    chk("d0_ext", ex0, q0.size() != 0 ? q0[0].ext : 1'b0);
    chk("d1_valid", v1, q1.size() != 0);
    chk("d1_count", cnt1, q1.size());
    chk("d1_ovf", of1, m_ovf1);
    chk("d1_ascii", as1, q1.size() != 0 ? q1[0].ascii : 8'h00);
    chk("d1_scan", sc1, q1.size() != 0 ? q1[0].scan : 8'h00);
    chk("d1_make", mk1, q1.size() != 0 ? q1[0].make : 1'b0);
    chk("d1_ext", ex1, q1.size() != 0 ? q1[0].ext : 1'b0);
    chk("shift0", sh0, m_lsh | m_rsh);
    chk("shift1", sh1, m_lsh | m_rsh);
    chk("caps0", cp0, m_caps);
    chk("caps1", cp1, m_caps);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rdy);
    bit  have;
    ev_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    if (rdy && q0.size() != 0) q0.delete(0);
    if (rdy && q1.size() != 0) q1.delete(0);
    if (st_v0) begin
      if (q0.size() < D0) q0.push_back(st_ev);
      else m_ovf0 = 1;
    end
    if (st_v1) begin
      if (q1.size() < D1) q1.push_back(st_ev);
      else m_ovf1 = 1;
    end
    st_v0 = 0;
    st_v1 = 0;
    if (v) begin
      model_byte(d, have, e);
      if (have) begin
        st_ev = e;
        st_v0 = e.make;
        st_v1 = 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; in_data = 8'h00; out_ready = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop_exp(input string name, input logic [7:0] exp);
    chk(name, as0, exp);
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [15];
    vecs = '{
      '{8'h00, 8'h1C, 8'h61}, '{8'h12, 8'h1C, 8'h41}, '{8'h00, 8'h1A, 8'h7A},
      '{8'h59, 8'h1A, 8'h5A}, '{8'h00, 8'h45, 8'h30}, '{8'h12, 8'h45, 8'h29},
      '{8'h59, 8'h16, 8'h21}, '{8'h12, 8'h46, 8'h28}, '{8'h00, 8'h3E, 8'h38},
      '{8'h00, 8'h29, 8'h20}, '{8'h00, 8'h5A, 8'h0D}, '{8'h12, 8'h66, 8'h08},
      '{8'h00, 8'h0E, 8'h00}, '{8'h12, 8'h4D, 8'h50}, '{8'h59, 8'h2E, 8'h25}
    };

    // Reset state and make/break with 2-cycle latency
    do_reset();
    chk("rst_valid", v0, 0);
    chk("rst_count", cnt0, 0);
    send(8'h1C);
    chk("lat_1cyc", v0, 0);
    send(8'hF0);
    chk("lat_2cyc", v0, 1);
    send(8'h1C);
    idle(1);
    chk("t1_cnt0", cnt0, 1);
    chk("t1_ascii", as0, 8'h61);
    chk("t1_scan", sc0, 8'h1C);
    chk("t1_make", mk0, 1);
    chk("t1_ext", ex0, 0);
    chk("t1_cnt1", cnt1, 2);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_brk_make", mk1, 0);
    chk("t1_brk_ascii", as1, 8'h61);
    chk("t1_empty", cnt0, 0);

    // Shift handling
    do_reset();
    send(8'h12); send(8'h1C); send(8'h16); send(8'hF0);
    chk("t2_shift_held", sh0, 1);
    send(8'h12);
    chk("t2_shift_rel", sh0, 0);
    send(8'h1C);
    idle(1);
    chk("t2_cnt", cnt0, 3);
    pop_exp("t2_A", 8'h41);
    pop_exp("t2_bang", 8'h21);
    pop_exp("t2_a", 8'h61);

    // Caps Lock
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    idle(1);
`ifdef PS2_KEYDEC_CAPSLOCK_EN
    chk("t3_caps", cp0, 1);
    chk("t3_cnt", cnt0, 1);
    send(8'h12); send(8'h1C);
    idle(1);
    pop_exp("t3_A", 8'h41);
    pop_exp("t3_a_shift", 8'h61);
`else
    chk("t3_caps", cp0, 0);
    chk("t3_cnt", cnt0, 2);
    chk("t3_scan58", sc0, 8'h58);
    pop_exp("t3_58", 8'h00);
    pop_exp("t3_a", 8'h61);
    chk("t3_cnt1", cnt1, 1);
`endif

    // Extended key and pause sequence
    do_reset();
    send(8'hE0); send(8'h75);
    idle(1);
    chk("t4_ascii", as0, 8'h00);
    chk("t4_scan", sc0, 8'h75);
    chk("t4_ext", ex0, 1);
    chk("t4_make", mk0, 1);
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h24);
    idle(2);
    chk("t4_pause_cnt0", cnt0, 1);
    chk("t4_pause_cnt1", cnt1, 1);
    chk("t4_pause_e", as0, 8'h65);

    // Overflow on the depth-4 instance, then drain in order
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    idle(1);
    chk("t5_cnt0", cnt0, D0);
    chk("t5_ovf0", of0, 1);
    chk("t5_cnt1", cnt1, 5);
    chk("t5_ovf1", of1, 0);
    pop_exp("t5_d0", 8'h61);
    pop_exp("t5_d1", 8'h62);
    pop_exp("t5_d2", 8'h63);
    pop_exp("t5_d3", 8'h64);
    chk("t5_drained", cnt0, 0);

    // Write and pop in the same cycle while full
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    step(1'b0, 8'h00, 1'b1);
    chk("t5b_ovf", of0, 0);
    chk("t5b_cnt", cnt0, D0);
    chk("t5b_head", as0, 8'h62);

    // Reset mid-prefix discards everything
    do_reset();
    send(8'h1C); send(8'hE0); send(8'hF0);
    do_reset();
    chk("t6_cleared", cnt0, 0);
    send(8'h1C);
    idle(2);
    chk("t6_cnt", cnt0, 1);
    chk("t6_ascii", as0, 8'h61);
    chk("t6_ext", ex0, 0);
    chk("t6_ovf", of0, 0);

    // ASCII table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].modk != 8'h00) send(vecs[i].modk);
      send(vecs[i].scan);
      if (vecs[i].modk != 8'h00) begin
        send(8'hF0);
        send(vecs[i].modk);
      end
      idle(1);
      chk($sformatf("tbl%0d_valid", i), v0, 1);
      chk($sformatf("tbl%0d_ascii", i), as0, vecs[i].exp_ascii);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
    end

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      int unsigned r;
      r = $urandom_range(0, 15);
      case (r)
        0:       b = 8'hE0;
        1, 2:    b = 8'hF0;
        3:       b = ($urandom_range(0, 5) == 0) ? 8'hE1 : 8'h12;
        4:       b = 8'h59;
        5:       b = 8'h58;
        6:       b = 8'($urandom_range(0, 255));
        default: b = 8'($urandom_range(8'h15, 8'h4D));
      endcase
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 99) < 60, b, $urandom_range(0, 99) < 45);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised successor to the flat scan-code-to-ASCII lookup. Consumes the raw PS/2 Set-2 byte stream from the PS/2 receiver, parses prefix bytes (E0 extended, F0 break, E1 pause), tracks Shift and Caps Lock state, and produces case- and shift-correct ASCII key events. Events are buffered in an internal FIFO that drains over a valid/ready handshake toward the display/console logic.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, minimum 2.
- `EMIT_BREAK`, default 0: 1 = break (release) events are also queued; 0 = only make events are queued.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` holds one received byte this cycle. There is no backpressure; every valid byte is consumed.
- `in_data` in 8: raw scan-code byte.
- `out_ready` in 1: consumer accepts the head event this cycle.
- `out_valid` out 1: FIFO non-empty.
- `out_ascii` out 8: ASCII of the head event; 0x00 if the key is unmapped.
- `out_scan` out 8: final scan code of the head event.
- `out_make` out 1: 1 = press, 0 = release.
- `out_ext` out 1: event carried the E0 prefix.
- `shift_held` out 1: left (0x12) or right (0x59) Shift is currently down.
- `caps_on` out 1: Caps Lock toggle state.
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full.
- `count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Parser FSM states are IDLE, EXT, BRK, EXT_BRK, and SKIP.
  - IDLE: E0→EXT; F0→BRK; E1→SKIP with skip counter 7; otherwise finish a make event.
  - EXT: F0→EXT_BRK; otherwise finish an extended make event, then go to IDLE.
  - BRK and EXT_BRK: finish a break event (extended for EXT_BRK), then go to IDLE.
  - SKIP: discard bytes and decrement the counter; return to IDLE after the 7th discarded byte.
  - A prefix byte arriving in a state other than IDLE: E0 and F0 are absorbed into the current prefix. E1 restarts SKIP.
- Modifier keys:
  - Non-extended 0x12 or 0x59 make sets the matching held bit; the break clears it.
  - `shift_held` is the OR of the two held bits.
  - 0x58 make toggles `caps_on`; 0x58 break has no effect.
  - Modifier events are never queued.
- ASCII map for non-extended keys only. Extended keys always give ASCII 0x00.
  - Digits 0–9: same codes as the base table. With shift, the digits give `)!@#$%^&*(` in key order 0..9.
  - Letters a–z: lowercase base codes. Uppercase when shift_held XOR caps_on.
  - 0x29 gives 0x20, 0x5A gives 0x0D, 0x66 gives 0x08.
  - All other codes give 0x00.
- The modifier state used for an event is the state *before* that event's byte.
- Event queueing:
  - A finished non-modifier event is queued if it is a make, or if it is a break and EMIT_BREAK=1.
  - If the FIFO is full at write time, the event is dropped and `overflow` is set.
- Typematic repeats (the same make repeated) are queued as separate events.

## Timing
- Reset values: FSM=IDLE, skip counter 0, shift bits 0, `caps_on`=0, FIFO empty, `out_valid`=0, `count`=0, `overflow`=0, all `out_*` data fields 0.
- A byte sampled at edge E updates the FSM and modifiers at E and registers the decoded event into a one-entry stage.
- The staged event is written to the FIFO at E+1. With an empty FIFO, `out_valid` rises after E+1, giving a 2-cycle latency.
- The stage accepts a new byte every cycle, so back-to-back `in_valid` is legal.
- Pop happens on `out_valid && out_ready` at the edge. Output fields are driven from the FIFO head and update after the pop.
- Simultaneous write and pop:
  - When full, the pop frees the slot, the write succeeds, and there is no overflow.
  - When empty, the write succeeds and `out_valid` rises; there is no bypass.
- `rst` mid-sequence (for example after E0 F0) discards the partial prefix, the staged event, and all FIFO contents.
- Pointers wrap modulo FIFO_DEPTH. Full is `count == FIFO_DEPTH`.

## Configuration
- `PS2_KEYDEC_CAPSLOCK_EN` defined: Caps Lock tracking is active as described above.
- `PS2_KEYDEC_CAPSLOCK_EN` undefined:
  - `caps_on` is tied to 0 and 0x58 is treated as an ordinary unmapped key.
  - 0x58 press/release events are queued with ASCII 0x00.
  - Letter case depends on shift only.

## Test plan
- Reset, then bytes 1C, F0, 1C with EMIT_BREAK=0 → one event {ascii 0x61, scan 0x1C, make 1, ext 0}. With EMIT_BREAK=1, a second event {0x61, 0x1C, make 0} follows.
- Bytes 12, 1C, 16, F0, 12, 1C → events 0x41 ('A') then 0x21 ('!'), then 0x61. `shift_held` falls after the F0 12 byte.
- Caps (macro on): 58, F0, 58, 1C → `caps_on`=1 and event 0x41. Adding held shift (12, 1C) → 0x61.
- Bytes E0, 75 → event {ascii 0x00, scan 0x75, ext 1}. Bytes E1 14 77 E1 F0 14 F0 77 followed by 24 → only the event 0x65.
- With `out_ready`=0, feed FIFO_DEPTH+1 make events → `count`=FIFO_DEPTH and `overflow`=1, and the first FIFO_DEPTH events drain in order. Pop and write in the same cycle while full → no additional overflow.
- Assert `rst` after E0 F0, then send 1C → make event 0x61 with ext=0, FIFO holds exactly 1 entry, `overflow`=0.
